md5_core_arbiter: RTL and testbench

Round-robin scheduler that shares one MD5 hashing core among `NUM_REQ` independent guess generators. It sits between the brute-force generators and the single hashing core. It accepts one guess at a time, drives the core's message handshake, and waits for the digest. It compares the digest against the target hash and latches the winning plaintext and requester ID on a match. The core is not pipelined, so at most one guess is in flight.

---
 rtl/md5_core_arbiter_pkg.sv | 21 ++
 rtl/md5_core_arbiter_picker.sv | 28 ++
 rtl/md5_core_arbiter.sv | 192 +++++++++++++++++++
 tb/tb_md5_core_arbiter.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/md5_core_arbiter_pkg.sv
// Shared types and helpers for the MD5 core arbiter (package md5_arb_pkg).
// Optional watchdog feature is selected in the top by MD5_ARB_TIMEOUT_EN.
package md5_arb_pkg;

    localparam int unsigned WORD_W = 128;
    localparam int unsigned LEN_W  = 8;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        CHECK,
        DONE
    } arb_state_t;

    // Legal message lengths are whole bytes from 8 to WORD_W bits.
    function automatic logic width_legal(input logic [LEN_W-1:0] w);
        return (w != '0) && (w <= LEN_W'(WORD_W)) && (w[2:0] == 3'b000);
    endfunction

endpackage

// File: rtl/md5_core_arbiter_picker.sv
// Combinational round-robin select: first asserted request after last_grant,
// wrapping around; 'any' flags that some request is present.
module rr_picker #(
    parameter int unsigned NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] last_grant,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       any
);

    localparam int unsigned ID_W = $clog2(NUM_REQ);

    always_comb begin : pick
        logic [ID_W-1:0] idx;
        idx      = '0;
        grant_id = '0;
        any      = 1'b0;
        for (int unsigned off = 1; off <= NUM_REQ; off++) begin
            idx = ID_W'((32'(last_grant) + off) % NUM_REQ);
            if (!any && req[idx]) begin
                any      = 1'b1;
                grant_id = idx;
            end
        end
    end

endmodule

// File: rtl/md5_core_arbiter.sv
// Round-robin scheduler sharing one non-pipelined MD5 core among NUM_REQ guess
// generators. Define MD5_ARB_TIMEOUT_EN to add the WAIT watchdog and timeout_err.
module md5_core_arbiter
    import md5_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ        = 4,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [0:WORD_W-1]            target_hash,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [NUM_REQ*WORD_W-1:0]    req_word,
    input  logic [NUM_REQ*LEN_W-1:0]     req_width,
    output logic [NUM_REQ-1:0]           req_ack,
    output logic [0:WORD_W-1]            core_msg,
    output logic [LEN_W-1:0]             core_width,
    output logic                         core_valid,
    input  logic                         core_ready,
    input  logic [0:WORD_W-1]            core_hash,
    input  logic                         core_hash_valid,
    output logic                         found,
    output logic [$clog2(NUM_REQ)-1:0]   found_id,
    output logic [0:WORD_W-1]            found_word,
    output logic                         busy
`ifdef MD5_ARB_TIMEOUT_EN
    ,
    output logic                         timeout_err
`endif
);

    localparam int unsigned ID_W = $clog2(NUM_REQ);

    if (NUM_REQ < 2 || TIMEOUT_CYCLES < 1) begin : g_cfg_check
        $error("md5_core_arbiter: NUM_REQ must be >= 2 and TIMEOUT_CYCLES >= 1");
    end

    arb_state_t state, state_nxt;

    logic [ID_W-1:0]  last_grant;
    logic [ID_W-1:0]  pick_id;
    logic             pick_any;
    logic [0:WORD_W-1] pick_word;
    logic [LEN_W-1:0] pick_width;

    logic [0:WORD_W-1] cur_word;
    logic [LEN_W-1:0] cur_width;
    logic [ID_W-1:0]  cur_id;
    logic [0:WORD_W-1] digest;

    logic grant;
    logic accept_hash;
    logic set_found;

    rr_picker #(
        .NUM_REQ (NUM_REQ)
    ) u_picker (
        .req        (req_valid),
        .last_grant (last_grant),
        .grant_id   (pick_id),
        .any        (pick_any)
    );

    always_comb begin
        pick_word  = req_word[32'(pick_id)*WORD_W +: WORD_W];
        pick_width = req_width[32'(pick_id)*LEN_W +: LEN_W];
    end

`ifdef MD5_ARB_TIMEOUT_EN
    localparam int unsigned CNT_W =
        ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

    logic [CNT_W-1:0] wait_cnt;
    logic             to_fire;

    // Counter reads 0 on the first WAIT cycle, so it fires on cycle TIMEOUT_CYCLES.
    always_ff @(posedge clock) begin
        if (reset) begin
            wait_cnt    <= '0;
            timeout_err <= 1'b0;
        end else begin
            if (state != WAIT) begin
                wait_cnt <= '0;
            end else begin
                wait_cnt <= wait_cnt + 1'b1;
            end
            if (to_fire) begin
                timeout_err <= 1'b1;
            end
        end
    end
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        grant       = 1'b0;
        accept_hash = 1'b0;
        set_found   = 1'b0;
`ifdef MD5_ARB_TIMEOUT_EN
        to_fire     = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (!found && pick_any) begin
                    grant = 1'b1;
                    if (width_legal(pick_width)) begin
                        state_nxt = ISSUE;
                    end
                end
            end
            ISSUE: begin
                if (core_ready) begin
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                // A digest landing on the limit cycle takes priority over the watchdog.
                if (core_hash_valid) begin
                    accept_hash = 1'b1;
                    state_nxt   = CHECK;
                end
`ifdef MD5_ARB_TIMEOUT_EN
                else if (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    to_fire   = 1'b1;
                    state_nxt = IDLE;
                end
`endif
            end
            CHECK: begin
                if (digest == target_hash) begin
                    set_found = 1'b1;
                    state_nxt = DONE;
                end else begin
                    state_nxt = IDLE;
                end
            end
            DONE: begin
                state_nxt = DONE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_comb begin
        core_valid = (state == ISSUE);
        busy       = (state == ISSUE) || (state == WAIT) || (state == CHECK);
        core_msg   = cur_word;
        core_width = cur_width;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            req_ack    <= '0;
            last_grant <= ID_W'(NUM_REQ - 1);
            cur_word   <= '0;
            cur_width  <= '0;
            cur_id     <= '0;
            digest     <= '0;
            found      <= 1'b0;
            found_id   <= '0;
            found_word <= '0;
        end else begin
            req_ack <= '0;
            if (grant) begin
                req_ack[pick_id] <= 1'b1;
                last_grant       <= pick_id;
                cur_word         <= pick_word;
                cur_width        <= pick_width;
                cur_id           <= pick_id;
            end
            if (accept_hash) begin
                digest <= core_hash;
            end
            if (set_found) begin
                found      <= 1'b1;
                found_id   <= cur_id;
                found_word <= cur_word;
            end
        end
    end

endmodule

// File: tb/tb_md5_core_arbiter.sv
// Scoreboard bench for md5_core_arbiter: stimulus pushes expectations, a negedge
// monitor pops and compares grants, core issues, found and state snapshots.
`timescale 1ns/1ps
module tb_md5_core_arbiter;

    localparam int unsigned NR = 4;
    localparam int unsigned TO = 20;
    localparam logic [127:0] MD5_A = 128'h0cc175b9c0f1a31ca7e5a0d4ae4f7d2e;

    typedef struct packed {
        logic [127:0] w;
        logic [7:0]   n;
    } guess_t;

    logic           clock = 1'b0;
    logic           reset;
    logic [127:0]   target_hash;
    logic [NR-1:0]  req_valid;
    logic [NR*128-1:0] req_word;
    logic [NR*8-1:0]   req_width;
    logic [NR-1:0]  req_ack;
    logic [127:0]   core_msg;
    logic [7:0]     core_width;
    logic           core_valid;
    logic           core_ready;
    logic [127:0]   core_hash;
    logic           core_hash_valid;
    logic           found;
    logic [1:0]     found_id;
    logic [127:0]   found_word;
    logic           busy;
    logic           timeout_err;

    always #5 clock = ~clock;

    md5_core_arbiter #(
        .NUM_REQ        (NR),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .target_hash     (target_hash),
        .req_valid       (req_valid),
        .req_word        (req_word),
        .req_width       (req_width),
        .req_ack         (req_ack),
        .core_msg        (core_msg),
        .core_width      (core_width),
        .core_valid      (core_valid),
        .core_ready      (core_ready),
        .core_hash       (core_hash),
        .core_hash_valid (core_hash_valid),
        .found           (found),
        .found_id        (found_id),
        .found_word      (found_word),
        .busy            (busy)
`ifdef MD5_ARB_TIMEOUT_EN
        ,
        .timeout_err     (timeout_err)
`endif
    );

`ifndef MD5_ARB_TIMEOUT_EN
    assign timeout_err = 1'b0;
`endif

    // Scoreboard queues
    int          exp_grant [$];
    guess_t      exp_msg   [$];
    logic [129:0] exp_found [$];
    string       st_name   [$];
    logic [7:0]  st_exp    [$];

    guess_t gq [NR][$];

    int   n_checks = 0;
    int   n_pass   = 0;
    logic end_req  = 1'b0;
    logic to_exp   = 1'b0;

    int   lat         = 3;
    int   ready_delay = 0;
    logic silent      = 1'b0;

    // ---------------- core model ----------------
    initial begin : core_model
        logic         acc;
        logic [127:0] m;
        logic [127:0] ph;
        int           pend;
        int           stall;
        core_ready      = 1'b0;
        core_hash_valid = 1'b0;
        core_hash       = '0;
        ph    = '0;
        pend  = 0;
        stall = 0;
        forever begin
            @(negedge clock);
            acc = core_valid && core_ready;
            m   = core_msg;
            @(posedge clock);
            #1;
            core_hash_valid = 1'b0;
            if (acc) begin
                pend       = lat;
                ph         = (m == 128'h61) ? MD5_A : ~m;
                core_ready = 1'b0;
                stall      = 0;
            end else if (pend > 0) begin
                pend--;
                if (pend == 0 && !silent) begin
                    core_hash_valid = 1'b1;
                    core_hash       = ph;
                end
            end
            if (!acc && core_valid && !core_ready) begin
                if (stall >= ready_delay) core_ready = 1'b1;
                else stall++;
            end
        end
    end

    // ---------------- monitor ----------------
    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, required %h", name, act, exp);
    endtask

    initial begin : monitor
        int           cyc;
        int           last_hv;
        int           last_acc;
        logic         prev_found;
        logic         prev_to;
        int           e;
        logic [129:0] f;
        cyc = 0; last_hv = 0; last_acc = 0; prev_found = 1'b0; prev_to = 1'b0;
        forever begin
            @(negedge clock);
            cyc++;
            if (cyc > 6000) begin
                $display("FAIL watchdog: cycle %0d reached, required end of run before 6000", cyc);
                n_checks++;
                $display("%0d/%0d checks passed", n_pass, n_checks);
                $finish;
            end
            while (st_name.size() > 0) begin
                chk(st_name.pop_front(), {found, busy, core_valid, timeout_err, req_ack}, st_exp.pop_front());
            end
            if (req_ack != '0) begin
                chk("ack_onehot", 128'($countones(req_ack)), 128'd1);
                if (exp_grant.size() == 0) begin
                    chk("grant_unexpected", {124'b0, req_ack}, '0);
                end else begin
                    e = exp_grant.pop_front();
                    chk("grant", {124'b0, req_ack}, 128'd1 << e);
                end
            end
            if (core_valid) begin
                if (exp_msg.size() == 0) begin
                    chk("issue_unexpected", {127'b0, core_valid}, '0);
                end else begin
                    chk("issue_msg", core_msg, exp_msg[0].w);
                    chk("issue_width", {120'b0, core_width}, {120'b0, exp_msg[0].n});
                    if (core_ready) begin
                        void'(exp_msg.pop_front());
                        last_acc = cyc;
                    end
                end
            end
            if (core_hash_valid) last_hv = cyc;
            if (found && !prev_found) begin
                if (exp_found.size() == 0) begin
                    chk("found_unexpected", {127'b0, found}, '0);
                end else begin
                    f = exp_found.pop_front();
                    chk("found_id", {126'b0, found_id}, {126'b0, f[129:128]});
                    chk("found_word", found_word, f[127:0]);
                    chk("found_latency", 128'(cyc - last_hv), 128'd2);
                end
            end
            prev_found = found;
            if (timeout_err && !prev_to) begin
                chk("timeout_latency", 128'(cyc - last_acc), 128'(TO + 1));
            end
            prev_to = timeout_err;
            if (end_req) begin
                chk("queues_drained",
                    128'(exp_grant.size() + exp_msg.size() + exp_found.size() + st_name.size()), '0);
                $display("%0d/%0d checks passed", n_pass, n_checks);
                $finish;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive();
        for (int i = 0; i < NR; i++) begin
            req_valid[i] = (gq[i].size() > 0);
            req_word[i*128 +: 128] = (gq[i].size() > 0) ? gq[i][0].w : '0;
            req_width[i*8 +: 8]    = (gq[i].size() > 0) ? gq[i][0].n : '0;
        end
    endtask

    // Generator side: an ack retires the head guess before the next edge.
    task automatic tick();
        @(posedge clock);
        #1;
        for (int i = 0; i < NR; i++) begin
            if (req_ack[i] && gq[i].size() > 0) void'(gq[i].pop_front());
        end
        drive();
    endtask

    task automatic add_guess(input int i, input logic [127:0] w, input logic [7:0] n);
        guess_t g;
        g.w = w;
        g.n = n;
        gq[i].push_back(g);
        drive();
    endtask

    task automatic expect_issue(input int i, input logic [127:0] w, input logic [7:0] n, input logic legal);
        guess_t g;
        g.w = w;
        g.n = n;
        exp_grant.push_back(i);
        if (legal) exp_msg.push_back(g);
    endtask

    task automatic push_state(input string name, input logic [6:0] v);
        st_name.push_back(name);
        st_exp.push_back({v[6:4], to_exp, v[3:0]});
    endtask

    task automatic wait_drain(input int budget);
        for (int k = 0; k < budget && (exp_grant.size() > 0 || exp_msg.size() > 0); k++) tick();
    endtask

    initial begin : stimulus
        reset       = 1'b1;
        target_hash = MD5_A;
        drive();
        repeat (3) tick();
        push_state("reset_state", 7'b000_0000);
        reset = 1'b0;

        // Round robin: all four hold guesses, 0 and 1 hold two each.
        for (int c = 0; c < 2; c++) begin
            for (int i = 0; i < NR; i++) begin
                if (c == 0 || i < 2) begin
                    expect_issue(i, 128'h1000 + 128'(i * 16 + c), 8'd16, 1'b1);
                    add_guess(i, 128'h1000 + 128'(i * 16 + c), 8'd16);
                end
            end
        end
        wait_drain(300);
        repeat (10) tick();
        push_state("rr_idle", 7'b000_0000);

        // Core stalls ready for 10 cycles.
        ready_delay = 10;
        expect_issue(1, 128'h2222, 8'd32, 1'b1);
        add_guess(1, 128'h2222, 8'd32);
        wait_drain(100);
        ready_delay = 0;
        repeat (10) tick();

        // Width 12 is acked and dropped; requester 3 follows.
        expect_issue(2, 128'h0fff, 8'd12, 1'b0);
        expect_issue(3, 128'h3333, 8'd24, 1'b1);
        add_guess(2, 128'h0fff, 8'd12);
        add_guess(3, 128'h3333, 8'd24);
        wait_drain(100);
        repeat (10) tick();

        // Reset while waiting for a matching digest.
        lat = 8;
        expect_issue(0, 128'h61, 8'd8, 1'b1);
        add_guess(0, 128'h61, 8'd8);
        wait_drain(100);
        repeat (2) tick();
        reset = 1'b1;
        tick();
        push_state("reset_in_wait", 7'b000_0000);
        reset = 1'b0;
        repeat (12) tick();
        push_state("stale_digest_ignored", 7'b000_0000);
        lat = 3;
        expect_issue(0, 128'h4444, 8'd16, 1'b1);
        expect_issue(2, 128'h5555, 8'd16, 1'b1);
        add_guess(0, 128'h4444, 8'd16);
        add_guess(2, 128'h5555, 8'd16);
        wait_drain(100);
        repeat (10) tick();

`ifdef MD5_ARB_TIMEOUT_EN
        // Silent core: watchdog fires, next requester is served.
        silent = 1'b1;
        expect_issue(3, 128'h6666, 8'd16, 1'b1);
        add_guess(3, 128'h6666, 8'd16);
        wait_drain(100);
        repeat (TO + 5) tick();
        to_exp = 1'b1;
        push_state("timeout_state", 7'b000_0000);
        silent = 1'b0;
        expect_issue(0, 128'h7777, 8'd16, 1'b1);
        expect_issue(1, 128'h8888, 8'd16, 1'b1);
        add_guess(0, 128'h7777, 8'd16);
        add_guess(1, 128'h8888, 8'd16);
        wait_drain(100);
        repeat (10) tick();
`endif

        // Matching guess "a" from requester 0.
        exp_found.push_back({2'd0, 128'h61});
        expect_issue(0, 128'h61, 8'd8, 1'b1);
        add_guess(0, 128'h61, 8'd8);
        wait_drain(100);
        repeat (10) tick();
        push_state("done_state", 7'b100_0000);
        add_guess(1, 128'h9999, 8'd16);
        repeat (20) tick();
        push_state("done_no_grant", 7'b100_0000);
        tick();
        end_req = 1'b1;
    end

endmodule
